// File: rtl/pqc_operand_issue.sv
// PQC operand issue stage: resolves x29/x30/x31, hands them to the PQC core,
// stalls the front end until the result returns. Optional: PQC_TIMEOUT_EN.
module pqc_operand_issue #(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     id_inst,
    input  logic            flush,
    input  logic [1:0]      reg29_sel,
    input  logic [1:0]      reg30_sel,
    input  logic [1:0]      reg31_sel,
    input  logic [XLEN-1:0] rf_x29,
    input  logic [XLEN-1:0] rf_x30,
    input  logic [XLEN-1:0] rf_x31,
    input  logic [XLEN-1:0] ex_fwd,
    input  logic [XLEN-1:0] mem_fwd,
    input  logic [XLEN-1:0] wb_fwd,
    output logic            pqc_valid,
    input  logic            pqc_ready,
    output logic [6:0]      pqc_funct7,
    output logic [XLEN-1:0] pqc_a,
    output logic [XLEN-1:0] pqc_b,
    output logic [XLEN-1:0] pqc_c,
    input  logic            pqc_done,
    input  logic [XLEN-1:0] pqc_result,
    output logic            stall,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            pqc_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t state, state_nx;

    logic            is_pqc;
    logic            capture;
    logic            result_ld;
    logic            timeout;
    logic [XLEN-1:0] op_a, op_b, op_c;

    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf_val,
        input logic [XLEN-1:0] ex_val,
        input logic [XLEN-1:0] mem_val,
        input logic [XLEN-1:0] wb_val
    );
        logic [XLEN-1:0] r;
        unique case (sel)
            2'd0:    r = rf_val;
            2'd1:    r = ex_val;
            2'd2:    r = mem_val;
            default: r = wb_val;
        endcase
        return r;
    endfunction

    assign is_pqc = id_valid
                  & (id_inst[6:0] == 7'b0001011)
                  & (id_inst[14:12] == 3'b011);

    assign op_a = fwd_mux(reg29_sel, rf_x29, ex_fwd, mem_fwd, wb_fwd);
    assign op_b = fwd_mux(reg30_sel, rf_x30, ex_fwd, mem_fwd, wb_fwd);
    assign op_c = fwd_mux(reg31_sel, rf_x31, ex_fwd, mem_fwd, wb_fwd);

    assign capture = (state == IDLE) & is_pqc & ~flush;

    // Core result is taken on done in BUSY or on ready+done together in ISSUE
    assign result_ld = ((state == BUSY) & pqc_done)
                     | ((state == ISSUE) & pqc_ready & pqc_done);

`ifdef PQC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] busy_cnt;

    // Watchdog: cleared on entry to BUSY, counts each BUSY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (state == ISSUE) begin
            busy_cnt <= '0;
        end else if (state == BUSY) begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end

    assign timeout = (state == BUSY) & ~pqc_done
                   & (busy_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (capture) state_nx = ISSUE;
            end
            ISSUE: begin
                if (pqc_ready & pqc_done) state_nx = WB;
                else if (pqc_ready)       state_nx = BUSY;
                else if (flush)           state_nx = IDLE;
            end
            BUSY: begin
                if (pqc_done | timeout) state_nx = WB;
            end
            WB: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        pqc_valid = 1'b0;
        stall     = 1'b0;
        wb_valid  = 1'b0;
        unique case (state)
            IDLE:  stall = is_pqc & ~flush;
            ISSUE: begin
                pqc_valid = 1'b1;
                stall     = 1'b1;
            end
            BUSY:  stall = 1'b1;
            WB:    wb_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand, destination and result latches
    always_ff @(posedge clk) begin
        if (rst) begin
            pqc_a      <= '0;
            pqc_b      <= '0;
            pqc_c      <= '0;
            pqc_funct7 <= '0;
            wb_rd      <= '0;
            wb_data    <= '0;
        end else begin
            if (capture) begin
                pqc_a      <= op_a;
                pqc_b      <= op_b;
                pqc_c      <= op_c;
                pqc_funct7 <= id_inst[31:25];
                wb_rd      <= id_inst[11:7];
            end
            if (result_ld) begin
                wb_data <= pqc_result;
            end else if (timeout) begin
                wb_data <= '0;
            end
        end
    end

`ifdef PQC_TIMEOUT_EN
    // Sticky timeout flag, cleared by the next capture
    always_ff @(posedge clk) begin
        if (rst) begin
            pqc_err <= 1'b0;
        end else if (capture) begin
            pqc_err <= 1'b0;
        end else if (timeout) begin
            pqc_err <= 1'b1;
        end
    end
`else
    assign pqc_err = 1'b0;
`endif

endmodule

// File: doc/pqc_operand_issue.md
Name: pqc_operand_issue

Overview:
- Decode-side issue stage for custom PQC instructions (opcode 7'b0001011, funct3 3'b011).
- Consumes the per-register forwarding selects for implicit operands x29/x30/x31 produced by the PQC data-stall/forward-select logic, resolves and latches the three operands, and hands them to the multi-cycle PQC core via a valid/ready handshake.
- Stalls the front of the pipeline until the core returns a result, then presents that result for writeback.

Parameters:
- XLEN, 64, operand/result width in bits.
- TIMEOUT_CYCLES, 1024, watchdog limit in BUSY (only used with PQC_TIMEOUT_EN).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  IF_ID holds a valid instruction.
- id_inst  in  32  IF_ID instruction word.
- flush  in  1  pipeline flush (branch/trap).
- reg29_sel  in  2  forwarding select for x29: 0 = regfile, 1 = EX, 2 = MEM, 3 = WB.
- reg30_sel  in  2  forwarding select for x30, same encoding.
- reg31_sel  in  2  forwarding select for x31, same encoding.
- rf_x29, rf_x30, rf_x31  in  XLEN each  register-file read values.
- ex_fwd, mem_fwd, wb_fwd  in  XLEN each  forwarded results from ID_EXE, EXE_MEM and MEM_WB.
- pqc_valid  out  1  operand bundle valid to core.
- pqc_ready  in  1  core accepts bundle.
- pqc_funct7  out  7  operation code (id_inst[31:25]).
- pqc_a, pqc_b, pqc_c  out  XLEN each  resolved x29, x30 and x31.
- pqc_done  in  1  core result strobe.
- pqc_result  in  XLEN  core result.
- stall  out  1  hold IF/ID and insert a bubble.
- wb_valid  out  1  result valid for writeback (one cycle).
- wb_rd  out  5  destination (latched id_inst[11:7]).
- wb_data  out  XLEN  latched result.
- pqc_err  out  1  timeout flag (tied 0 without PQC_TIMEOUT_EN).

Behaviour:
- is_pqc = id_valid & id_inst[6:0]==7'b0001011 & id_inst[14:12]==3'b011.
- Operand mux per register: sel 0 → rf value, 1 → ex_fwd, 2 → mem_fwd, 3 → wb_fwd.
- FSM states: IDLE, ISSUE, BUSY, WB.
- IDLE:
  - If is_pqc & !flush: latch the three muxed operands, funct7 and rd → ISSUE.
  - stall = is_pqc & !flush (combinational), so IF_ID holds the instruction during the capture cycle.
- ISSUE:
  - pqc_valid=1; operands and funct7 are held stable until accepted.
  - flush & !pqc_ready → IDLE (abort, no writeback).
  - pqc_ready & pqc_done in the same cycle → latch result → WB.
  - pqc_ready alone → BUSY.
  - A flush in the same cycle as pqc_ready is ignored; the instruction is committed.
- BUSY:
  - pqc_done → latch pqc_result into wb_data → WB.
  - flush is ignored.
- WB:
  - wb_valid=1 for exactly one cycle → IDLE.
  - stall deasserts in this cycle so IF_ID advances past the PQC instruction.
- stall = 1 in ISSUE and BUSY; 0 in WB.
- Minimum latency, is_pqc to wb_valid: 2 cycles when ready and done arrive together in the ISSUE cycle.
- pqc_valid drops the cycle after acceptance. A new PQC instruction is not captured in the WB cycle; it is captured in the next IDLE cycle.
- Reset (including mid-operation):
  - State → IDLE.
  - pqc_valid, stall, wb_valid, pqc_err, wb_rd, wb_data, pqc_a, pqc_b, pqc_c, pqc_funct7 all → 0.
  - Any in-flight core response after reset is ignored while in IDLE.
- pqc_done outside ISSUE/BUSY is ignored.
- All datapaths are XLEN wide; no arithmetic is performed.

Optional Feature:
- Macro: PQC_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without pqc_done: go to WB with wb_data=0 and pqc_err=1 (pqc_err is held until the next capture or reset).
- Undefined: no counter; BUSY waits indefinitely; pqc_err tied to 0.

Test Plan:
- All sels = 0, rf_x29/x30/x31 = 0x11/0x22/0x33, ready held high, done 3 cycles later with result 0xABCD, rd=5 → pqc_a/b/c = 0x11/0x22/0x33; wb_valid for 1 cycle with wb_rd=5, wb_data=0xABCD; stall high from capture through the last BUSY cycle.
- reg29_sel=1, reg30_sel=2, reg31_sel=3 with ex/mem/wb_fwd = 0xA/0xB/0xC → pqc_a/b/c = 0xA/0xB/0xC.
- pqc_ready withheld 4 cycles, then flush → return to IDLE, no wb_valid, stall low the next cycle.
- pqc_ready and pqc_done in the same ISSUE cycle with result 0x7 → wb_valid asserted exactly one cycle later with wb_data=0x7.
- rst asserted during BUSY, then a stray pqc_done → all outputs 0, no wb_valid.
- PQC_TIMEOUT_EN with TIMEOUT_CYCLES=8, done never asserted → wb_valid with wb_data=0 and pqc_err=1 after 8 BUSY cycles.
